// File: rtl/uart_alu_intf.sv
// Command sequencer between the UART RX/TX FIFOs and an external combinational ALU.
// Pops operand A, operand B and opcode, captures the ALU result, then pushes it to TX.
module uart_alu_intf #(
  parameter int DBIT = 8,
  parameter int OP_W = 6
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_rx_empty,
  input  logic [DBIT-1:0] i_r_data,
  output logic            o_rd_uart,
  input  logic            i_tx_full,
  output logic            o_wr_uart,
  output logic [DBIT-1:0] o_w_data,
  output logic [DBIT-1:0] o_alu_a,
  output logic [DBIT-1:0] o_alu_b,
  output logic [OP_W-1:0] o_alu_op,
  input  logic [DBIT-1:0] i_alu_result,
  output logic            o_busy
);

  typedef enum logic [2:0] {
    S_GET_A  = 3'd0,
    S_GET_B  = 3'd1,
    S_GET_OP = 3'd2,
    S_EXEC   = 3'd3,
    S_SEND   = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [DBIT-1:0] a_q, a_d;
  logic [DBIT-1:0] b_q, b_d;
  logic [OP_W-1:0] op_q, op_d;
  logic [DBIT-1:0] result_q, result_d;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= S_GET_A;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    result_d  = result_q;
    o_rd_uart = 1'b0;
    o_wr_uart = 1'b0;
    case (state_q)
      S_GET_A: begin
        if (!i_rx_empty) begin
          o_rd_uart = 1'b1;
          a_d       = i_r_data;
          state_d   = S_GET_B;
        end
      end
      S_GET_B: begin
        if (!i_rx_empty) begin
          o_rd_uart = 1'b1;
          b_d       = i_r_data;
          state_d   = S_GET_OP;
        end
      end
      S_GET_OP: begin
        if (!i_rx_empty) begin
          o_rd_uart = 1'b1;
          op_d      = i_r_data[OP_W-1:0];
          state_d   = S_EXEC;
        end
      end
      S_EXEC: begin
        result_d = i_alu_result;
        state_d  = S_SEND;
      end
      S_SEND: begin
        // Result stays parked here while the TX FIFO is full.
        if (!i_tx_full) begin
          o_wr_uart = 1'b1;
          state_d   = S_GET_A;
        end
      end
      default: state_d = S_GET_A;
    endcase
  end

  assign o_w_data = result_q;
  assign o_alu_a  = a_q;
  assign o_alu_b  = b_q;
  assign o_alu_op = op_q;
  assign o_busy   = (state_q != S_GET_A);

endmodule

// File: tb/tb_uart_alu_intf.sv
// Self-checking bench for uart_alu_intf: RX FIFO queue model, ALU model and a
// scoreboard of expected results checked whenever the DUT pushes to TX.
module tb_uart_alu_intf;

  localparam int DBIT = 8;
  localparam int OP_W = 6;

  typedef struct {
    logic [DBIT-1:0] a;
    logic [DBIT-1:0] b;
    logic [OP_W-1:0] op;
    logic [DBIT-1:0] res;
  } cmd_t;

  logic            clk;
  logic            i_reset;
  logic            i_rx_empty;
  logic [DBIT-1:0] i_r_data;
  logic            o_rd_uart;
  logic            i_tx_full;
  logic            o_wr_uart;
  logic [DBIT-1:0] o_w_data;
  logic [DBIT-1:0] o_alu_a;
  logic [DBIT-1:0] o_alu_b;
  logic [OP_W-1:0] o_alu_op;
  logic [DBIT-1:0] i_alu_result;
  logic            o_busy;

  logic [DBIT-1:0] rxQ[$];
  cmd_t            expQ[$];
  int              popLog[$];
  int              errCount = 0;
  int              checkCount = 0;
  int              cycle = 0;
  int              popCount = 0;
  int              wrCount = 0;
  int              wrCycle = 0;
  logic            rdSeen = 1'b0;

  uart_alu_intf #(.DBIT(DBIT), .OP_W(OP_W)) dut (
    .i_clk        (clk),
    .i_reset      (i_reset),
    .i_rx_empty   (i_rx_empty),
    .i_r_data     (i_r_data),
    .o_rd_uart    (o_rd_uart),
    .i_tx_full    (i_tx_full),
    .o_wr_uart    (o_wr_uart),
    .o_w_data     (o_w_data),
    .o_alu_a      (o_alu_a),
    .o_alu_b      (o_alu_b),
    .o_alu_op     (o_alu_op),
    .i_alu_result (i_alu_result),
    .o_busy       (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DBIT-1:0] aluRef(input logic [DBIT-1:0] a,
                                             input logic [DBIT-1:0] b,
                                             input logic [OP_W-1:0] op);
    case (op)
      6'h20:   aluRef = a + b;
      6'h22:   aluRef = a - b;
      6'h24:   aluRef = a & b;
      6'h25:   aluRef = a | b;
      default: aluRef = a ^ b;
    endcase
  endfunction

  assign i_alu_result = aluRef(o_alu_a, o_alu_b, o_alu_op);

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cycle);
    end
  endtask

  // RX FIFO model and TX monitor: pop after the edge, refresh head, sample at negedge.
  always begin
    @(posedge clk);
    #1;
    cycle++;
    if (rdSeen && rxQ.size() > 0) void'(rxQ.pop_front());
    #2;
    i_rx_empty = (rxQ.size() == 0);
    i_r_data   = (rxQ.size() > 0) ? rxQ[0] : '0;
    @(negedge clk);
    rdSeen = (o_rd_uart === 1'b1);
    if (rdSeen) begin
      popCount++;
      popLog.push_back(cycle);
    end
    if (o_rd_uart === 1'b1 && o_wr_uart === 1'b1)
      checkOutput("popAndPush", 1, 0);
    if (o_wr_uart === 1'b1) begin
      wrCount++;
      wrCycle = cycle;
      if (expQ.size() == 0) begin
        checkOutput("unexpectedWr", 1, 0);
      end else begin
        cmd_t e;
        e = expQ.pop_front();
        checkOutput("wData", o_w_data, e.res);
        checkOutput("aluA", o_alu_a, e.a);
        checkOutput("aluB", o_alu_b, e.b);
        checkOutput("aluOp", o_alu_op, e.op);
      end
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic applyStimulus(input logic [DBIT-1:0] a, input logic [DBIT-1:0] b,
                               input logic [DBIT-1:0] opByte, input bit expectWr);
    cmd_t e;
    e.a   = a;
    e.b   = b;
    e.op  = opByte[OP_W-1:0];
    e.res = aluRef(a, b, opByte[OP_W-1:0]);
    rxQ.push_back(a);
    rxQ.push_back(b);
    rxQ.push_back(opByte);
    if (expectWr) expQ.push_back(e);
  endtask

  task automatic waitWrites(input int target, input int budget);
    int n = 0;
    while (wrCount < target && n < budget) begin
      waitCycles(1);
      n++;
    end
    if (wrCount < target) checkOutput("wrTimeout", wrCount, target);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int base;
    int wr0;
    int relCycle;
    i_reset    = 1'b1;
    i_tx_full  = 1'b0;
    i_rx_empty = 1'b1;
    i_r_data   = '0;

    // Reset state
    waitCycles(2);
    checkOutput("rstRd", o_rd_uart, 0);
    checkOutput("rstWr", o_wr_uart, 0);
    checkOutput("rstWData", o_w_data, 0);
    checkOutput("rstAluA", o_alu_a, 0);
    checkOutput("rstAluB", o_alu_b, 0);
    checkOutput("rstAluOp", o_alu_op, 0);
    checkOutput("rstBusy", o_busy, 0);
    i_reset = 1'b0;
    waitCycles(2);

    // Preloaded ADD: three consecutive pops, write four cycles after the first pop
    $display("[TB] preloaded ADD command");
    popLog.delete();
    applyStimulus(8'h05, 8'h03, 8'h20, 1'b1);
    waitWrites(1, 20);
    checkOutput("t2Pops", popLog.size(), 3);
    if (popLog.size() == 3) begin
      checkOutput("t2PopGap1", popLog[1] - popLog[0], 1);
      checkOutput("t2PopGap2", popLog[2] - popLog[1], 1);
      checkOutput("t2Latency", wrCycle - popLog[0], 4);
    end
    waitCycles(2);
    checkOutput("t2Idle", o_busy, 0);

    // Bytes trickle in ten cycles apart; 8-bit wrap on the sum
    $display("[TB] slow arrival with wrap");
    base = popCount;
    wr0  = wrCount;
    expQ.push_back('{a: 8'hFF, b: 8'h01, op: 6'h20, res: 8'h00});
    rxQ.push_back(8'hFF);
    waitCycles(10);
    checkOutput("t3Pop1", popCount - base, 1);
    checkOutput("t3Busy1", o_busy, 1);
    rxQ.push_back(8'h01);
    waitCycles(10);
    checkOutput("t3Pop2", popCount - base, 2);
    checkOutput("t3HoldA", o_alu_a, 8'hFF);
    checkOutput("t3HoldB", o_alu_b, 8'h01);
    checkOutput("t3NoWr", wrCount - wr0, 0);
    rxQ.push_back(8'h20);
    waitWrites(wr0 + 1, 20);
    checkOutput("t3Pop3", popCount - base, 3);

    // TX full back-pressure in the send state
    $display("[TB] TX full stall");
    wr0 = wrCount;
    i_tx_full = 1'b1;
    applyStimulus(8'h07, 8'h02, 8'h22, 1'b1);
    waitCycles(8);
    checkOutput("t4Busy", o_busy, 1);
    checkOutput("t4WData1", o_w_data, 8'h05);
    waitCycles(12);
    checkOutput("t4WData2", o_w_data, 8'h05);
    checkOutput("t4NoWr", wrCount - wr0, 0);
    i_tx_full = 1'b0;
    relCycle = cycle;
    waitWrites(wr0 + 1, 10);
    checkOutput("t4FirstCycle", wrCycle, relCycle);
    waitCycles(3);
    checkOutput("t4Single", wrCount - wr0, 1);

    // Reset mid-command discards partial operands
    $display("[TB] reset mid-command");
    wr0 = wrCount;
    rxQ.push_back(8'h11);
    rxQ.push_back(8'h22);
    waitCycles(5);
    checkOutput("t5PreA", o_alu_a, 8'h11);
    checkOutput("t5PreB", o_alu_b, 8'h22);
    i_reset = 1'b1;
    #1;
    checkOutput("t5RstA", o_alu_a, 0);
    checkOutput("t5RstB", o_alu_b, 0);
    checkOutput("t5RstBusy", o_busy, 0);
    checkOutput("t5RstWData", o_w_data, 0);
    waitCycles(1);
    i_reset = 1'b0;
    waitCycles(3);
    checkOutput("t5NoWr", wrCount - wr0, 0);
    applyStimulus(8'h01, 8'h02, 8'h20, 1'b1);
    waitWrites(wr0 + 1, 20);

    // Four back-to-back commands, opcode byte upper bits ignored on the last
    $display("[TB] four preloaded commands");
    base = popCount;
    wr0  = wrCount;
    applyStimulus(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'h20, 1'b1);
    applyStimulus(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'h22, 1'b1);
    applyStimulus(8'hC3, 8'h5A, 8'h24, 1'b1);
    applyStimulus(8'h90, 8'h0F, 8'hE5, 1'b1);
    waitWrites(wr0 + 4, 60);
    waitCycles(3);
    checkOutput("t6Pops", popCount - base, 12);
    checkOutput("t6Wrs", wrCount - wr0, 4);
    checkOutput("t6ExpEmpty", expQ.size(), 0);
    checkOutput("t6Idle", o_busy, 0);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
